// File: rtl/cache_mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_rd_arbiter
//  Purpose  : Shares one memory read channel among NUM_REQ cache read masters;
//             ARB_RR_EN selects round-robin instead of highest-index priority.
//  Revision : 1.0  initial release
// ============================================================================
module cache_mem_rd_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    from_cache_rd_req_valid,
    input  logic [32*NUM_REQ-1:0] from_cache_rd_req_addr,
    input  logic [8*NUM_REQ-1:0]  from_cache_rd_req_len,
    output logic [NUM_REQ-1:0]    to_cache_rd_req_ready,
    output logic [NUM_REQ-1:0]    to_cache_rd_rsp_valid,
    output logic [31:0]           to_cache_rd_rsp_data,
    output logic                  to_cache_rd_rsp_last,
    input  logic [NUM_REQ-1:0]    from_cache_rd_rsp_ready,
    output logic                  to_mem_rd_req_valid,
    output logic [31:0]           to_mem_rd_req_addr,
    output logic [7:0]            to_mem_rd_req_len,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [31:0]           from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] c_ST_IDLE = 3'b001;
    localparam logic [2:0] c_ST_REQ  = 3'b010;
    localparam logic [2:0] c_ST_RSP  = 3'b100;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] w_win;
    logic [31:0]   r_addr_q;
    logic [7:0]    r_len_q;
    logic          w_any;
    logic          w_accept;
    logic          w_beat_done;

    assign w_any       = |from_cache_rd_req_valid;
    assign w_accept    = (r_state == c_ST_IDLE) && w_any;
    assign w_beat_done = (r_state == c_ST_RSP) && from_mem_rd_rsp_valid &&
                         from_cache_rd_rsp_ready[r_grant] && from_mem_rd_rsp_last;

`ifdef ARB_RR_EN
    logic [GW-1:0] r_ptr;
    logic [GW:0]   w_idx;

    // Scan from the far end toward ptr so the candidate closest to ptr wins.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (GW + 1)'(k);
            if (w_idx >= (GW + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (GW + 1)'(NUM_REQ);
            end
            if (from_cache_rd_req_valid[w_idx[GW-1:0]]) begin
                w_win = w_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (from_cache_rd_req_valid[i]) begin
                w_win = GW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_addr_q <= '0;
            r_len_q  <= '0;
        end else if (w_accept) begin
            r_grant  <= w_win;
            r_addr_q <= from_cache_rd_req_addr[int'(w_win)*32 +: 32];
            r_len_q  <= from_cache_rd_req_len[int'(w_win)*8 +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any)                 w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (from_mem_rd_req_ready) w_state_nxt = c_ST_RSP;
            c_ST_RSP:  if (w_beat_done)           w_state_nxt = c_ST_IDLE;
            default:                              w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Ready is gated by rst since it is combinational on the request valids.
    always_comb begin
        to_cache_rd_req_ready = '0;
        to_cache_rd_rsp_valid = '0;
        to_mem_rd_req_valid   = 1'b0;
        to_mem_rd_rsp_ready   = 1'b0;
        if (w_accept && !rst) begin
            to_cache_rd_req_ready = NUM_REQ'(1) << w_win;
        end
        if (r_state == c_ST_REQ) begin
            to_mem_rd_req_valid = 1'b1;
        end
        if (r_state == c_ST_RSP) begin
            to_cache_rd_rsp_valid = NUM_REQ'(from_mem_rd_rsp_valid) << r_grant;
            to_mem_rd_rsp_ready   = from_cache_rd_rsp_ready[r_grant];
        end
    end

    assign to_mem_rd_req_addr   = r_addr_q;
    assign to_mem_rd_req_len    = r_len_q;
    assign to_cache_rd_rsp_data = from_mem_rd_rsp_data;
    assign to_cache_rd_rsp_last = from_mem_rd_rsp_last;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_rd_arbiter
//  Purpose  : Directed self-checking bench for cache_mem_rd_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_mem_rd_arbiter;

    localparam int NR = 2;

    logic          clk;
    logic          rst;
    logic [NR-1:0] from_cache_rd_req_valid;
    logic [63:0]   from_cache_rd_req_addr;
    logic [15:0]   from_cache_rd_req_len;
    logic [NR-1:0] to_cache_rd_req_ready;
    logic [NR-1:0] to_cache_rd_rsp_valid;
    logic [31:0]   to_cache_rd_rsp_data;
    logic          to_cache_rd_rsp_last;
    logic [NR-1:0] from_cache_rd_rsp_ready;
    logic          to_mem_rd_req_valid;
    logic [31:0]   to_mem_rd_req_addr;
    logic [7:0]    to_mem_rd_req_len;
    logic          from_mem_rd_req_ready;
    logic          from_mem_rd_rsp_valid;
    logic [31:0]   from_mem_rd_rsp_data;
    logic          from_mem_rd_rsp_last;
    logic          to_mem_rd_rsp_ready;

    int n_chk  = 0;
    int n_pass = 0;
    int first;
    int second;

    cache_mem_rd_arbiter #(.NUM_REQ(NR)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .from_cache_rd_req_valid (from_cache_rd_req_valid),
        .from_cache_rd_req_addr  (from_cache_rd_req_addr),
        .from_cache_rd_req_len   (from_cache_rd_req_len),
        .to_cache_rd_req_ready   (to_cache_rd_req_ready),
        .to_cache_rd_rsp_valid   (to_cache_rd_rsp_valid),
        .to_cache_rd_rsp_data    (to_cache_rd_rsp_data),
        .to_cache_rd_rsp_last    (to_cache_rd_rsp_last),
        .from_cache_rd_rsp_ready (from_cache_rd_rsp_ready),
        .to_mem_rd_req_valid     (to_mem_rd_req_valid),
        .to_mem_rd_req_addr      (to_mem_rd_req_addr),
        .to_mem_rd_req_len       (to_mem_rd_req_len),
        .from_mem_rd_req_ready   (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid   (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data    (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last    (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready     (to_mem_rd_rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after acceptance; plays memory for one burst.
    task automatic serve(input int r, input logic [31:0] a, input logic [7:0] l,
                         input logic [31:0] d0, input int dly, input int bp_beat,
                         input int stop_at);
        logic [NR-1:0] oh;
        oh = NR'(1) << r;
        #1;
        check("busy_req_rdy", to_cache_rd_req_ready, 0);
        check("mem_req_valid", to_mem_rd_req_valid, 1);
        check("mem_req_addr", to_mem_rd_req_addr, a);
        check("mem_req_len", to_mem_rd_req_len, l);
        check("req_no_rsp", to_mem_rd_rsp_ready, 0);
        repeat (dly) begin
            tick();
            #1 check("mem_req_hold", to_mem_rd_req_valid, 1);
        end
        from_mem_rd_req_ready = 1'b1;
        tick();
        from_mem_rd_req_ready = 1'b0;
        #1 check("mem_req_done", to_mem_rd_req_valid, 0);
        from_cache_rd_rsp_ready[r] = 1'b1;
        for (int b = 0; b <= int'(l); b++) begin
            from_mem_rd_rsp_valid = 1'b1;
            from_mem_rd_rsp_data  = d0 + 32'(b);
            from_mem_rd_rsp_last  = (b == int'(l));
            if (b == stop_at) return;
            if (b == bp_beat) begin
                from_cache_rd_rsp_ready[r] = 1'b0;
                repeat (3) begin
                    #1;
                    check("bp_mem_rdy", to_mem_rd_rsp_ready, 0);
                    check("bp_rsp_valid", to_cache_rd_rsp_valid, oh);
                    tick();
                end
                from_cache_rd_rsp_ready[r] = 1'b1;
            end
            #1;
            check("rsp_valid", to_cache_rd_rsp_valid, oh);
            check("rsp_data", to_cache_rd_rsp_data, d0 + 32'(b));
            check("rsp_last", to_cache_rd_rsp_last, (b == int'(l)) ? 1 : 0);
            check("rsp_mem_rdy", to_mem_rd_rsp_ready, 1);
            tick();
        end
        from_mem_rd_rsp_valid   = 1'b0;
        from_mem_rd_rsp_last    = 1'b0;
        from_cache_rd_rsp_ready = '0;
    endtask

    initial begin
        rst                     = 1'b1;
        from_cache_rd_req_valid = 2'b11;
        from_cache_rd_req_addr  = {32'h0000_4000, 32'h0000_2000};
        from_cache_rd_req_len   = {8'd7, 8'd7};
        from_cache_rd_rsp_ready = '0;
        from_mem_rd_req_ready   = 1'b0;
        from_mem_rd_rsp_valid   = 1'b1;
        from_mem_rd_rsp_data    = 32'h1234_5678;
        from_mem_rd_rsp_last    = 1'b1;
        #2;
        check("rst_req_rdy", to_cache_rd_req_ready, 0);
        check("rst_rsp_valid", to_cache_rd_rsp_valid, 0);
        check("rst_mem_req_valid", to_mem_rd_req_valid, 0);
        check("rst_mem_rsp_rdy", to_mem_rd_rsp_ready, 0);
        check("rst_addr", to_mem_rd_req_addr, 0);
        check("rst_len", to_mem_rd_req_len, 0);
        check("rst_data_pass", to_cache_rd_rsp_data, 32'h1234_5678);
        check("rst_last_pass", to_cache_rd_rsp_last, 1);
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
        tick();
        tick();

        // Simultaneous requests straight out of reset
`ifdef ARB_RR_EN
        first = 0;
`else
        first = 1;
`endif
        second = 1 - first;
        rst = 1'b0;
        #1 check("sim_acc_first", to_cache_rd_req_ready, NR'(1) << first);
        tick();
        from_cache_rd_req_valid[first] = 1'b0;
        serve(first, (first == 1) ? 32'h4000 : 32'h2000, 8'd7,
              (first == 1) ? 32'h40 : 32'h20, 1, -1, -1);
        #1 check("sim_acc_second", to_cache_rd_req_ready, NR'(1) << second);
        tick();
        from_cache_rd_req_valid[second] = 1'b0;
        serve(second, (second == 1) ? 32'h4000 : 32'h2000, 8'd7,
              (second == 1) ? 32'h40 : 32'h20, 0, -1, -1);

        // Single I-Cache request, memory ready after 2 cycles
        from_cache_rd_req_addr[31:0] = 32'h0000_1000;
        from_cache_rd_req_len[7:0]   = 8'd7;
        from_cache_rd_req_valid[0]   = 1'b1;
        #1 check("single_acc", to_cache_rd_req_ready, 2'b01);
        tick();
        from_cache_rd_req_valid[0] = 1'b0;
        serve(0, 32'h1000, 8'd7, 32'h10, 2, -1, -1);
        from_mem_rd_rsp_valid = 1'b1;
        #1;
        check("idle_stray_rdy", to_mem_rd_rsp_ready, 0);
        check("idle_stray_valid", to_cache_rd_rsp_valid, 0);
        check("idle_no_mem_req", to_mem_rd_req_valid, 0);
        from_mem_rd_rsp_valid = 1'b0;

        // Back-pressure, with a D-Cache request waiting behind it
        from_cache_rd_req_addr[31:0] = 32'h0000_3000;
        from_cache_rd_req_len[7:0]   = 8'd3;
        from_cache_rd_req_valid[0]   = 1'b1;
        #1 check("bp_acc", to_cache_rd_req_ready, 2'b01);
        tick();
        from_cache_rd_req_valid[0]    = 1'b0;
        from_cache_rd_req_addr[63:32] = 32'h0000_0004;
        from_cache_rd_req_len[15:8]   = 8'd0;
        from_cache_rd_req_valid[1]    = 1'b1;
        serve(0, 32'h3000, 8'd3, 32'h30, 0, 1, -1);

        // Single-beat D-Cache burst, I-Cache follows in the next IDLE cycle
        #1 check("byp_acc", to_cache_rd_req_ready, 2'b10);
        tick();
        from_cache_rd_req_valid[1]   = 1'b0;
        from_cache_rd_req_addr[31:0] = 32'h0000_5000;
        from_cache_rd_req_len[7:0]   = 8'd1;
        from_cache_rd_req_valid[0]   = 1'b1;
        serve(1, 32'h0000_0004, 8'd0, 32'hDEAD_BEEF, 0, -1, -1);
        #1 check("byp_next_acc", to_cache_rd_req_ready, 2'b01);
        tick();
        from_cache_rd_req_valid[0] = 1'b0;
        serve(0, 32'h5000, 8'd1, 32'h50, 0, -1, -1);

        // Reset while beat 3 of 8 is on the bus
        from_cache_rd_req_addr[31:0] = 32'h0000_6000;
        from_cache_rd_req_len[7:0]   = 8'd7;
        from_cache_rd_req_valid[0]   = 1'b1;
        #1 check("mid_acc", to_cache_rd_req_ready, 2'b01);
        tick();
        from_cache_rd_req_valid[0] = 1'b0;
        serve(0, 32'h6000, 8'd7, 32'h60, 0, -1, 3);
        from_cache_rd_req_valid = 2'b01;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", to_cache_rd_rsp_valid, 0);
        check("mid_rst_mem_rdy", to_mem_rd_rsp_ready, 0);
        check("mid_rst_req_rdy", to_cache_rd_req_ready, 0);
        check("mid_rst_mem_req", to_mem_rd_req_valid, 0);
        check("mid_rst_addr", to_mem_rd_req_addr, 0);
        tick();
        rst                          = 1'b0;
        from_mem_rd_rsp_valid        = 1'b0;
        from_mem_rd_rsp_last         = 1'b0;
        from_cache_rd_rsp_ready      = '0;
        from_cache_rd_req_addr[31:0] = 32'h0000_7000;
        from_cache_rd_req_len[7:0]   = 8'd2;
        #1 check("post_rst_acc", to_cache_rd_req_ready, 2'b01);
        tick();
        from_cache_rd_req_valid[0] = 1'b0;
        serve(0, 32'h7000, 8'd2, 32'h70, 1, -1, -1);
        #1 check("final_idle", to_mem_rd_req_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_rd_arbiter.md
# cache_mem_rd_arbiter

Shares the single memory read channel among `NUM_REQ` cache read masters: requester 0 is the I-Cache and requester 1 is the D-Cache in the default build. It sits between the caches' `to_mem_rd_*` / `from_mem_rd_*` ports and the memory/IO read port. It grants one requester at a time, issues that requester's captured request to memory, then routes the burst response back to it. The channel is held until the last beat completes.

## Interface
- `NUM_REQ`, default 2: number of requesters; `GW = $clog2(NUM_REQ)`.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `from_cache_rd_req_valid` in `NUM_REQ`: per-requester read request valid.
- `from_cache_rd_req_addr` in `32*NUM_REQ`: requester i uses bits `[32i+31:32i]`.
- `from_cache_rd_req_len` in `8*NUM_REQ`: requester i uses bits `[8i+7:8i]`; burst length minus 1.
- `to_cache_rd_req_ready` in/out: out `NUM_REQ`; one-hot acceptance.
- `to_cache_rd_rsp_valid` out `NUM_REQ`: one-hot beat valid.
- `to_cache_rd_rsp_data` out 32: beat data, broadcast to all requesters.
- `to_cache_rd_rsp_last` out 1: last-beat flag, broadcast.
- `from_cache_rd_rsp_ready` in `NUM_REQ`: per-requester beat ready.
- `to_mem_rd_req_valid` out 1: memory request valid.
- `to_mem_rd_req_addr` out 32: captured address.
- `to_mem_rd_req_len` out 8: captured length.
- `from_mem_rd_req_ready` in 1: memory request ready.
- `from_mem_rd_rsp_valid` in 1: memory beat valid.
- `from_mem_rd_rsp_data` in 32: memory beat data.
- `from_mem_rd_rsp_last` in 1: memory last beat.
- `to_mem_rd_rsp_ready` out 1: beat ready to memory.

## Operation
- FSM has three states: `IDLE`, `REQ`, `RSP`. It is one-hot encoded.
- Registered state: `grant[GW-1:0]`, `addr_q[31:0]`, `len_q[7:0]`, and the round-robin pointer `ptr[GW-1:0]`.
- **IDLE**
  - If any `from_cache_rd_req_valid` bit is set, the arbiter picks a winner `w`.
  - `to_cache_rd_req_ready[w]` = 1, combinationally, in the same cycle. All other ready bits are 0.
  - At the clock edge: `grant<=w`, `addr_q`/`len_q` <= w's fields, and the FSM moves to `REQ`.
  - If no request is valid, the FSM stays in `IDLE` and all ready bits are 0.
- **REQ**
  - `to_mem_rd_req_valid`=1, with `addr_q`/`len_q` driven to memory.
  - When `from_mem_rd_req_ready` is seen, the FSM moves to `RSP`. Otherwise it holds; there is no timeout.
- **RSP**
  - `to_cache_rd_rsp_valid[grant] = from_mem_rd_rsp_valid`; all other valid bits are 0.
  - `to_mem_rd_rsp_ready = from_cache_rd_rsp_ready[grant]`.
  - A beat that has valid, ready and `from_mem_rd_rsp_last` all set moves the FSM to `IDLE`.
  - Only `last` ends the burst; `len_q` is not checked.
- Data and last pass through combinationally: `to_cache_rd_rsp_data = from_mem_rd_rsp_data` and `to_cache_rd_rsp_last = from_mem_rd_rsp_last`, in all states.
- Outside `RSP`, `to_mem_rd_rsp_ready`=0 and all `to_cache_rd_rsp_valid`=0. Any stray memory beat is therefore never accepted.
- A requester must not change its request after acceptance. The caches hold rsp_ready low until their own receive state.

## Timing
- Reset is asynchronous:
  - State returns to `IDLE`; `grant`, `ptr`, `addr_q` and `len_q` are cleared to 0.
  - All outputs are 0 while `rst`=1: every ready/valid output, and the addr/len outputs.
  - Data/last outputs follow memory.
- A reset in the middle of a burst aborts it with no cleanup. Memory and the caches are reset by the same `rst`.
- Acceptance costs 0 cycles: ready is asserted in the cycle valid is seen in `IDLE`.
- The memory request appears exactly 1 cycle after acceptance.
- There is exactly 1 `IDLE` cycle between consecutive transactions. A new grant can happen in that cycle.
- Response beats add no latency: valid, data and last are combinational from memory to the cache.
- A single-beat burst (`len`=0, last on the first beat) returns the FSM to `IDLE` on the next edge.
- If requests arrive while the FSM is busy, they wait with ready=0. Their valid stays asserted.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration. The search starts at `ptr` and wraps modulo `NUM_REQ`.
  - On each grant, `ptr <= (w+1) mod NUM_REQ`.
  - With 2 requesters that both stay valid, grants alternate.
- `ARB_RR_EN` undefined:
  - Fixed priority: the highest index wins, so the D-Cache beats the I-Cache.
  - `ptr` is not implemented.

## Test plan
- Single request:
  - Stimulus: I-Cache valid, addr=0x0000_1000, len=7; memory ready after 2 cycles; 8 beats 0x10..0x17 with last on 0x17.
  - Required response: ready[0] pulses once; the memory sees 0x1000/7; the I-Cache gets 8 beats in order; the FSM is back in `IDLE` the next cycle.
- Simultaneous requests from reset:
  - Stimulus: I-Cache 0x2000 and D-Cache 0x4000 both valid, len=7 each.
  - Required response with `ARB_RR_EN`: D-Cache... no — the I-Cache is granted first (`ptr`=0), then the D-Cache.
  - Required response without it: the D-Cache is granted first, then the I-Cache.
- Back-pressure:
  - Stimulus: hold `from_cache_rd_rsp_ready[grant]`=0 for 3 cycles while `from_mem_rd_rsp_valid`=1.
  - Required response: `to_mem_rd_rsp_ready`=0 and the beat is held; it completes when ready rises.
  - The other requester's rsp_valid stays 0 throughout.
- Bypass single beat:
  - Stimulus: D-Cache addr=0x0000_0004, len=0; one beat 0xDEAD_BEEF with last.
  - Required response: 1 beat is delivered; a following I-Cache request is accepted in the next `IDLE` cycle.
- Reset mid-burst:
  - Stimulus: assert `rst` after beat 3 of 8.
  - Required response: all valid/ready outputs go to 0 immediately; after release, a new request proceeds normally from `IDLE`.
